// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps at most one
// instruction-memory request in flight, buffers returned words in a small
// prefetch queue and presents {instruction, PC+2} to the IF/ID register.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              ifid_write,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_add2_out,
  output logic              instr_valid
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] pc_hold;
  logic              outstanding;
  logic              discard;

  logic [DATA_W-1:0] q_instr [QDEPTH];
  logic [ADDR_W-1:0] q_pc    [QDEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  logic ack_ok;
  logic issue;
  logic push;
  logic pop;

  // Handshake and queue-control decisions for this cycle; redirect overrides
  // both enqueue and consume, and an ack with nothing in flight is ignored.
  always_comb begin
    ack_ok = imem_ack && outstanding;
    issue  = !outstanding && !redirect && (count < CW'(QDEPTH));
    push   = ack_ok && !discard && !redirect;
    pop    = (count != '0) && ifid_write && !redirect;
  end

  // Fetch PC, request tracking and the owed-response discard flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else begin
      if (redirect)
        fetch_pc <= redirect_pc & ~ADDR_W'(1);
      else if (issue)
        fetch_pc <= fetch_pc + ADDR_W'(2);

      if (issue) begin
        outstanding <= 1'b1;
        req_addr    <= fetch_pc;
      end else if (ack_ok) begin
        outstanding <= 1'b0;
      end

      // Only one response can ever be owed, so repeated redirects keep it at 1.
      if (ack_ok)
        discard <= 1'b0;
      else if (redirect && outstanding)
        discard <= 1'b1;
    end
  end

  // Queue pointers, occupancy and the last presented PC+2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pc_hold <= '0;
    end else begin
      if (count != '0)
        pc_hold <= q_pc[head];
      if (redirect) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push)
          tail <= tail + PW'(1);
        if (pop)
          head <= head + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Queue storage; contents are qualified by count so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= req_addr + ADDR_W'(2);
    end
  end

  // Memory request is held from the issuing edge until its ack; the head
  // entry drives IF/ID directly, with a NOP bubble when the queue is empty.
  always_comb begin
    imem_req    = outstanding;
    imem_addr   = req_addr;
    instr_valid = (count != '0);
    instr_out   = instr_valid ? q_instr[head] : '0;
    pc_add2_out = instr_valid ? q_pc[head] : pc_hold;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait and slow memory, stall release,
// redirect with a discarded response, redirect colliding with an ack,
// address wrap and asynchronous reset mid-request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ifid_write;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pc_add2_out;
  logic        instr_valid;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .QDEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_write(ifid_write),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_add2_out(pc_add2_out),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] ins,
                         input logic [15:0] pc);
    chk({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, v});
    chk({tag, ".instr"}, instr_out, ins);
    chk({tag, ".pc2"}, pc_add2_out, pc);
  endtask

  task automatic chk_req(input string tag, input logic r, input logic [15:0] a);
    chk({tag, ".req"}, {15'd0, imem_req}, {15'd0, r});
    if (r) chk({tag, ".addr"}, imem_addr, a);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 16'h0000;
    ifid_write = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
    step(); step();
    chk_req("rst", 1'b0, 16'h0000);
    chk("rst.addr", imem_addr, 16'h0000);
    chk_out("rst", 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;

    // Zero-wait memory, consumer always ready.
    step();
    chk_req("zw0", 1'b1, 16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'hA000;
    step();
    chk_out("zw0", 1'b1, 16'hA000, 16'h0002);
    chk_req("zw0gap", 1'b0, 16'h0000);
    imem_ack = 1'b0;
    step();
    chk_req("zw1", 1'b1, 16'h0002);
    chk_out("zw_bubble", 1'b0, 16'h0000, 16'h0002);
    imem_ack = 1'b1; imem_rdata = 16'hA002;
    step();
    chk_out("zw1", 1'b1, 16'hA002, 16'h0004);
    imem_ack = 1'b0;
    step();
    chk_req("zw2", 1'b1, 16'h0004);
    imem_ack = 1'b1; imem_rdata = 16'hA004;
    step();
    chk_out("zw2", 1'b1, 16'hA004, 16'h0006);
    imem_ack = 1'b0; ifid_write = 1'b0;
    step();
    chk_req("zw3", 1'b1, 16'h0006);

    // Asynchronous reset while a request is in flight.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h9999;
    #1;
    chk_req("arst", 1'b0, 16'h0000);
    chk("arst.addr", imem_addr, 16'h0000);
    chk_out("arst", 1'b0, 16'h0000, 16'h0000);
    step();
    rst = 1'b0;
    // Stray ack with nothing outstanding must not enqueue anything.
    step();
    chk_out("stray", 1'b0, 16'h0000, 16'h0000);
    chk_req("slow0", 1'b1, 16'h0000);
    imem_ack = 1'b0;

    // Three-cycle memory latency with IF/ID stalled.
    step();
    chk_req("slow0h1", 1'b1, 16'h0000);
    step();
    chk_req("slow0h2", 1'b1, 16'h0000);
    imem_ack = 1'b1; imem_rdata = 16'hB000;
    step();
    chk_out("slow0", 1'b1, 16'hB000, 16'h0002);
    chk_req("slow0gap", 1'b0, 16'h0000);
    imem_ack = 1'b0;
    step();
    chk_req("slow1", 1'b1, 16'h0002);
    step();
    step();
    chk_req("slow1h", 1'b1, 16'h0002);
    imem_ack = 1'b1; imem_rdata = 16'hB002;
    step();
    imem_ack = 1'b0;
    chk_req("full0", 1'b0, 16'h0000);
    step();
    step();
    chk_req("full1", 1'b0, 16'h0000);
    chk_out("full", 1'b1, 16'hB000, 16'h0002);

    // Stall release for one cycle.
    ifid_write = 1'b1;
    step();
    ifid_write = 1'b0;
    chk_out("rel", 1'b1, 16'hB002, 16'h0004);
    chk_req("rel", 1'b0, 16'h0000);
    step();
    chk_req("rel_next", 1'b1, 16'h0004);

    // Simultaneous push and pop with a single entry.
    imem_ack = 1'b1; imem_rdata = 16'hB004; ifid_write = 1'b1;
    step();
    imem_ack = 1'b0; ifid_write = 1'b0;
    chk_out("pushpop", 1'b1, 16'hB004, 16'h0006);
    step();
    chk_req("pre_redir", 1'b1, 16'h0006);

    // Redirect while 0x0006 is outstanding; its response must be dropped.
    redirect = 1'b1; redirect_pc = 16'h0041;
    step();
    redirect = 1'b0;
    chk_out("redir_flush", 1'b0, 16'h0000, 16'h0006);
    chk_req("redir_hold", 1'b1, 16'h0006);
    step();
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    chk_out("beef_drop", 1'b0, 16'h0000, 16'h0006);
    chk_req("beef_gap", 1'b0, 16'h0000);
    step();
    chk_req("redir_req", 1'b1, 16'h0040);
    imem_ack = 1'b1; imem_rdata = 16'hC040;
    step();
    imem_ack = 1'b0;
    chk_out("redir_first", 1'b1, 16'hC040, 16'h0042);
    step();
    chk_req("coll_pre", 1'b1, 16'h0042);

    // Redirect coinciding with ack while one entry is queued.
    imem_ack = 1'b1; imem_rdata = 16'hDEAD; redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    imem_ack = 1'b0; redirect = 1'b0;
    chk_out("coll", 1'b0, 16'h0000, 16'h0042);
    chk_req("coll", 1'b0, 16'h0000);
    step();
    chk_req("wrap0", 1'b1, 16'hFFFE);
    imem_ack = 1'b1; imem_rdata = 16'hE0FE;
    step();
    imem_ack = 1'b0;
    chk_out("wrap", 1'b1, 16'hE0FE, 16'h0000);
    step();
    chk_req("wrap1", 1'b1, 16'h0000);

    // Reset mid-request again, from a non-empty queue.
    rst = 1'b1;
    #1;
    chk_req("arst2", 1'b0, 16'h0000);
    chk_out("arst2", 1'b0, 16'h0000, 16'h0000);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
